i2c_rx_ctrl: RTL and testbench

- I2C target-side receive sequencer for write transactions.
- Synchronises SCL/SDA, detects START/STOP and arms an external byte receiver (rx_en/rx_read/rxdone/rx byte interface) per byte.
- Checks the address byte, drives ACK/NACK on the 9th clock, and hands data bytes to the core through a one-entry valid/ready holding register.
- Sits between the pad-level open-drain SDA/SCL and the byte receiver.

---
 rtl/i2c_rx_ctrl_pkg.sv | 24 ++
 rtl/i2c_rx_ctrl_if.sv | 30 +++
 rtl/i2c_rx_ctrl_cond_det.sv | 50 +++++
 rtl/i2c_rx_ctrl.sv | 147 ++++++++++++++
 tb/tb_i2c_rx_ctrl.sv | 389 ++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/i2c_rx_ctrl_pkg.sv
// Shared types and constants for the I2C target receive sequencer.
// Imported by the condition detector and the top-level controller.
package i2c_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ADDR,
    ST_ADDR_CHK,
    ST_ACK_WAIT,
    ST_ACK_HOLD,
    ST_DATA,
    ST_DATA_CHK,
    ST_IGNORE
  } i2c_rx_ctrl_state_e;

  localparam logic I2C_ACK      = 1'b1;
  localparam logic I2C_NACK     = 1'b0;
  localparam logic I2C_RW_WRITE = 1'b0;

  function automatic logic addr_match(input logic [7:0] byte_in, input logic [6:0] tgt);
    return (byte_in[7:1] == tgt) && (byte_in[0] == I2C_RW_WRITE);
  endfunction

endpackage

// File: rtl/i2c_rx_ctrl_if.sv
// Bundles pad, byte-receiver and core-side signals of i2c_rx_ctrl.
// slave = the controller itself, master = whatever surrounds it.
interface i2c_rx_ctrl_if;
  logic       scl_i;
  logic       sda_i;
  logic       sda_oe_o;
  logic       rx_scl_o;
  logic       rx_sda_o;
  logic       rx_en_o;
  logic       rx_read_o;
  logic       rxdone_i;
  logic [7:0] rx_i;
  logic [7:0] data_o;
  logic       data_valid_o;
  logic       data_ready_i;
  logic       busy_o;
  logic       overrun_o;

  modport slave (
    input  scl_i, sda_i, rxdone_i, rx_i, data_ready_i,
    output sda_oe_o, rx_scl_o, rx_sda_o, rx_en_o, rx_read_o,
           data_o, data_valid_o, busy_o, overrun_o
  );

  modport master (
    output scl_i, sda_i, rxdone_i, rx_i, data_ready_i,
    input  sda_oe_o, rx_scl_o, rx_sda_o, rx_en_o, rx_read_o,
           data_o, data_valid_o, busy_o, overrun_o
  );
endinterface

// File: rtl/i2c_rx_ctrl_cond_det.sv
// SCL/SDA synchronisers plus START/STOP and SCL edge strobes.
// Synchronisers reset to 1 so an idle bus never looks like a START.
module i2c_cond_det #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic i_scl,
  input  logic i_sda,
  output logic o_scl,
  output logic o_sda,
  output logic o_start,
  output logic o_stop,
  output logic o_scl_rise,
  output logic o_scl_fall
);

  logic [SYNC_STAGES-1:0] r_scl_sync;
  logic [SYNC_STAGES-1:0] r_sda_sync;
  logic                   r_scl_q;
  logic                   r_sda_q;
  logic                   w_scl;
  logic                   w_sda;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_scl_sync <= '1;
      r_sda_sync <= '1;
      r_scl_q    <= 1'b1;
      r_sda_q    <= 1'b1;
    end else begin
      r_scl_sync <= {r_scl_sync[SYNC_STAGES-2:0], i_scl};
      r_sda_sync <= {r_sda_sync[SYNC_STAGES-2:0], i_sda};
      r_scl_q    <= w_scl;
      r_sda_q    <= w_sda;
    end
  end

  assign w_scl = r_scl_sync[SYNC_STAGES-1];
  assign w_sda = r_sda_sync[SYNC_STAGES-1];

  // SCL must be high on both samples so an SDA change at an SCL edge is not a condition.
  assign o_start    = w_scl & r_scl_q & r_sda_q & ~w_sda;
  assign o_stop     = w_scl & r_scl_q & ~r_sda_q & w_sda;
  assign o_scl_rise = w_scl & ~r_scl_q;
  assign o_scl_fall = ~w_scl & r_scl_q;
  assign o_scl      = w_scl;
  assign o_sda      = w_sda;

endmodule

// File: rtl/i2c_rx_ctrl.sv
// I2C target write-receive sequencer: address check, ACK/NACK drive and a
// one-entry valid/ready holding register towards the core.
module i2c_rx_ctrl
  import i2c_pkg::*;
#(
  parameter logic [6:0] TARGET_ADDR = 7'h42,
  parameter int         SYNC_STAGES = 2
) (
  input logic          clk_i,
  input logic          rst_i,
  i2c_rx_ctrl_if.slave bus
);

  i2c_rx_ctrl_state_e r_state, w_state_nxt;
  logic       r_ack, w_ack_nxt;
  logic       r_sda_oe, w_sda_oe_nxt;
  logic       r_busy, w_busy_nxt;
  logic       r_rx_read, w_rx_read_nxt;
  logic       r_overrun, w_overrun_nxt;
  logic       w_load;
  logic [7:0] r_data;
  logic       r_valid;

  logic w_scl, w_sda, w_start, w_stop, w_scl_rise, w_scl_fall;

  i2c_cond_det #(.SYNC_STAGES(SYNC_STAGES)) u_cond_det (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .i_scl      (bus.scl_i),
    .i_sda      (bus.sda_i),
    .o_scl      (w_scl),
    .o_sda      (w_sda),
    .o_start    (w_start),
    .o_stop     (w_stop),
    .o_scl_rise (w_scl_rise),
    .o_scl_fall (w_scl_fall)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state   <= ST_IDLE;
      r_ack     <= I2C_NACK;
      r_sda_oe  <= 1'b0;
      r_busy    <= 1'b0;
      r_rx_read <= 1'b0;
      r_overrun <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_ack     <= w_ack_nxt;
      r_sda_oe  <= w_sda_oe_nxt;
      r_busy    <= w_busy_nxt;
      r_rx_read <= w_rx_read_nxt;
      r_overrun <= w_overrun_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_ack_nxt     = r_ack;
    w_sda_oe_nxt  = r_sda_oe;
    w_busy_nxt    = r_busy;
    w_overrun_nxt = 1'b0;
    w_load        = 1'b0;

    case (r_state)
      ST_IDLE: begin
        if (w_start) w_state_nxt = ST_ADDR;
      end
      ST_ADDR: begin
        if (bus.rxdone_i) w_state_nxt = ST_ADDR_CHK;
      end
      ST_ADDR_CHK: begin
        if (addr_match(bus.rx_i, TARGET_ADDR)) begin
          w_ack_nxt  = I2C_ACK;
          w_busy_nxt = 1'b1;
        end else begin
          w_ack_nxt  = I2C_NACK;
        end
        w_state_nxt = ST_ACK_WAIT;
      end
      ST_ACK_WAIT: begin
        if (w_scl_fall) begin
          w_sda_oe_nxt = r_ack;
          w_state_nxt  = ST_ACK_HOLD;
        end
      end
      ST_ACK_HOLD: begin
        if (w_scl_fall) begin
          w_sda_oe_nxt = 1'b0;
          w_state_nxt  = (r_ack == I2C_ACK) ? ST_DATA : ST_IGNORE;
        end
      end
      ST_DATA: begin
        if (bus.rxdone_i) w_state_nxt = ST_DATA_CHK;
      end
      ST_DATA_CHK: begin
        if (!r_valid || bus.data_ready_i) begin
          w_load    = 1'b1;
          w_ack_nxt = I2C_ACK;
        end else begin
          w_ack_nxt     = I2C_NACK;
          w_overrun_nxt = 1'b1;
        end
        w_state_nxt = ST_ACK_WAIT;
      end
      ST_IGNORE: begin
        w_sda_oe_nxt = 1'b0;
      end
      default: w_state_nxt = ST_IDLE;
    endcase

    // Bus conditions abort whatever byte is in flight.
    if (r_state != ST_IDLE && (w_stop || w_start)) begin
      w_state_nxt   = w_stop ? ST_IDLE : ST_ADDR;
      w_sda_oe_nxt  = 1'b0;
      w_busy_nxt    = 1'b0;
      w_load        = 1'b0;
      w_overrun_nxt = 1'b0;
    end

    w_rx_read_nxt = ((w_state_nxt == ST_ADDR) && ((r_state != ST_ADDR) || w_start)) ||
                    ((w_state_nxt == ST_DATA) && (r_state != ST_DATA));
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_data  <= 8'h00;
      r_valid <= 1'b0;
    end else if (w_load) begin
      r_data  <= bus.rx_i;
      r_valid <= 1'b1;
    end else if (r_valid && bus.data_ready_i) begin
      r_valid <= 1'b0;
    end
  end

  assign bus.sda_oe_o     = r_sda_oe;
  assign bus.rx_scl_o     = w_scl;
  assign bus.rx_sda_o     = w_sda;
  assign bus.rx_en_o      = (r_state != ST_IDLE);
  assign bus.rx_read_o    = r_rx_read;
  assign bus.data_o       = r_data;
  assign bus.data_valid_o = r_valid;
  assign bus.busy_o       = r_busy;
  assign bus.overrun_o    = r_overrun;

endmodule

// File: tb/tb_i2c_rx_ctrl.sv
// Bench for i2c_rx_ctrl: bit-level I2C controller model, behavioural byte
// receiver, and a transaction-level reference model of ACKs and delivered bytes.
module tb_i2c_rx_ctrl;

  localparam int HP = 10;

  logic clk = 1'b0;
  logic rst;
  logic tb_sda;
  always #5 clk = ~clk;

  i2c_rx_ctrl_if ifc ();
  assign ifc.sda_i = tb_sda & ~ifc.sda_oe_o;   // open-drain wired-AND

  i2c_rx_ctrl #(.TARGET_ADDR(7'h42), .SYNC_STAGES(2)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (ifc)
  );

  int chk_cnt = 0;
  int pass_cnt = 0;

  // ---------------- monitor ----------------
  logic [7:0] got_q[$];
  int ovr_cnt = 0;
  int rd_cnt  = 0;

  initial begin
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (ifc.data_valid_o && ifc.data_ready_i) got_q.push_back(ifc.data_o);
        if (ifc.overrun_o) ovr_cnt++;
        if (ifc.rx_read_o) rd_cnt++;
      end
    end
  end

  // ---------------- byte receiver model ----------------
  bit         rcv_armed, rcv_pend, rcv_prev;
  int         rcv_cnt;
  logic [7:0] rcv_sh;

  initial begin
    ifc.rxdone_i = 1'b0;
    ifc.rx_i     = 8'h00;
    rcv_armed = 0; rcv_pend = 0; rcv_prev = 1; rcv_cnt = 0; rcv_sh = 8'h00;
    forever begin
      @(posedge clk);
      #1;
      ifc.rxdone_i = 1'b0;
      if (rcv_pend) begin
        ifc.rx_i = rcv_sh;
        rcv_pend = 0;
      end else begin
        ifc.rx_i = 8'($urandom);
      end
      if (rst || !ifc.rx_en_o) rcv_armed = 0;
      if (ifc.rx_read_o) begin
        rcv_armed = 1;
        rcv_cnt   = 0;
      end else if (rcv_armed && ifc.rx_scl_o && !rcv_prev) begin
        rcv_sh = {rcv_sh[6:0], ifc.rx_sda_o};
        rcv_cnt++;
        if (rcv_cnt == 8) begin
          ifc.rxdone_i = 1'b1;
          rcv_armed    = 0;
          rcv_pend     = 1;
        end
      end
      rcv_prev = ifc.rx_scl_o;
    end
  end

  // ---------------- reference model (transaction level) ----------------
  bit         m_addressed;
  bit         m_full;
  logic [7:0] m_byte;
  logic [7:0] exp_q[$];
  int         exp_ovr = 0;

  function automatic bit model_addr(input logic [7:0] a);
    m_addressed = (a == {7'h42, 1'b0});
    return m_addressed;
  endfunction

  function automatic bit model_data(input logic [7:0] d, input bit ready);
    if (!m_addressed) return 1'b0;
    if (ready) begin
      if (m_full) exp_q.push_back(m_byte);
      m_full = 0;
      exp_q.push_back(d);
      return 1'b1;
    end
    if (!m_full) begin
      m_full = 1;
      m_byte = d;
      return 1'b1;
    end
    exp_ovr++;
    return 1'b0;
  endfunction

  function automatic void model_ready_rise();
    if (m_full) exp_q.push_back(m_byte);
    m_full = 0;
  endfunction

  function automatic bit queues_match();
    if (got_q.size() != exp_q.size()) return 1'b0;
    foreach (got_q[i]) if (got_q[i] !== exp_q[i]) return 1'b0;
    return 1'b1;
  endfunction

  // ---------------- bus driver ----------------
  task automatic hp();
    repeat (HP) @(posedge clk);
    #1;
  endtask

  task automatic i2c_start();
    tb_sda = 1'b1; hp();
    ifc.scl_i = 1'b1; hp();
    tb_sda = 1'b0; hp();
    ifc.scl_i = 1'b0; hp();
  endtask

  task automatic i2c_stop();
    tb_sda = 1'b0; hp();
    ifc.scl_i = 1'b1; hp();
    tb_sda = 1'b1; hp();
  endtask

  task automatic send_bit(input logic b);
    tb_sda = b; hp();
    ifc.scl_i = 1'b1; hp();
    ifc.scl_i = 1'b0; hp();
  endtask

  task automatic ack_bit(output logic a);
    tb_sda = 1'b1; hp();
    ifc.scl_i = 1'b1;
    repeat (HP/2) @(posedge clk);
    #1;
    a = ifc.sda_oe_o;
    repeat (HP/2) @(posedge clk);
    #1;
    ifc.scl_i = 1'b0; hp();
  endtask

  task automatic xfer_byte(input logic [7:0] b, output logic a);
    for (int i = 7; i >= 0; i--) send_bit(b[i]);
    ack_bit(a);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    chk_cnt++;
    if ({ifc.sda_oe_o, ifc.rx_en_o, ifc.rx_read_o, ifc.data_valid_o, ifc.busy_o,
         ifc.overrun_o, ifc.data_o} !== 14'h0)
      $display("FAIL reset_outputs: got %b required all 0", {ifc.sda_oe_o, ifc.rx_en_o,
               ifc.rx_read_o, ifc.data_valid_o, ifc.busy_o, ifc.overrun_o, ifc.data_o});
    else pass_cnt++;
    chk_cnt++;
    if ({ifc.rx_scl_o, ifc.rx_sda_o} !== 2'b11)
      $display("FAIL reset_sync: got %b required 11", {ifc.rx_scl_o, ifc.rx_sda_o});
    else pass_cnt++;
    rst = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    chk_cnt++;
    if (ifc.rx_en_o !== 1'b0) $display("FAIL reset_no_false_start: rx_en %b required 0", ifc.rx_en_o);
    else pass_cnt++;
  endtask

  task automatic test_write_basic();
    logic a;
    bit   e;
    ifc.data_ready_i = 1'b1;
    i2c_start();
    xfer_byte(8'h84, a); e = model_addr(8'h84);
    chk_cnt++; if (a !== e) $display("FAIL basic_addr_ack: got %b required %b", a, e); else pass_cnt++;
    chk_cnt++; if (ifc.busy_o !== 1'b1) $display("FAIL basic_busy: got %b required 1", ifc.busy_o); else pass_cnt++;
    xfer_byte(8'hA5, a); e = model_data(8'hA5, 1);
    chk_cnt++; if (a !== e) $display("FAIL basic_data0_ack: got %b required %b", a, e); else pass_cnt++;
    xfer_byte(8'h3C, a); e = model_data(8'h3C, 1);
    chk_cnt++; if (a !== e) $display("FAIL basic_data1_ack: got %b required %b", a, e); else pass_cnt++;
    i2c_stop(); m_addressed = 0;
    hp();
    chk_cnt++;
    if ({ifc.busy_o, ifc.rx_en_o} !== 2'b00)
      $display("FAIL basic_stop: busy/rx_en %b required 00", {ifc.busy_o, ifc.rx_en_o});
    else pass_cnt++;
    chk_cnt++;
    if (!queues_match()) $display("FAIL basic_delivered: got %0d bytes required %0d", got_q.size(), exp_q.size());
    else pass_cnt++;
  endtask

  task automatic test_addr_mismatch();
    logic a;
    bit   e;
    int   rd0;
    rd0 = rd_cnt;
    i2c_start();
    xfer_byte(8'h86, a); e = model_addr(8'h86);
    chk_cnt++; if (a !== e) $display("FAIL mismatch_addr_ack: got %b required %b", a, e); else pass_cnt++;
    xfer_byte(8'h55, a); e = model_data(8'h55, 1);
    chk_cnt++; if (a !== e) $display("FAIL mismatch_data_ack: got %b required %b", a, e); else pass_cnt++;
    chk_cnt++; if (rd_cnt - rd0 !== 1) $display("FAIL mismatch_rx_read: got %0d pulses required 1", rd_cnt - rd0); else pass_cnt++;
    chk_cnt++;
    if ({ifc.rx_en_o, ifc.busy_o, ifc.data_valid_o} !== 3'b100)
      $display("FAIL mismatch_ignore: en/busy/valid %b required 100", {ifc.rx_en_o, ifc.busy_o, ifc.data_valid_o});
    else pass_cnt++;
    i2c_stop(); m_addressed = 0;
    hp();
    chk_cnt++; if (ifc.rx_en_o !== 1'b0) $display("FAIL mismatch_stop: rx_en %b required 0", ifc.rx_en_o); else pass_cnt++;
  endtask

  task automatic test_read_req();
    logic a;
    bit   e;
    i2c_start();
    xfer_byte(8'h85, a); e = model_addr(8'h85);
    chk_cnt++; if (a !== e) $display("FAIL read_addr_ack: got %b required %b", a, e); else pass_cnt++;
    i2c_stop(); m_addressed = 0;
    i2c_start();
    xfer_byte(8'h84, a); e = model_addr(8'h84);
    chk_cnt++; if (a !== e) $display("FAIL read_next_addr_ack: got %b required %b", a, e); else pass_cnt++;
    xfer_byte(8'h11, a); e = model_data(8'h11, 1);
    chk_cnt++; if (a !== e) $display("FAIL read_next_data_ack: got %b required %b", a, e); else pass_cnt++;
    i2c_stop(); m_addressed = 0;
    hp();
    chk_cnt++;
    if (!queues_match()) $display("FAIL read_delivered: got %0d bytes required %0d", got_q.size(), exp_q.size());
    else pass_cnt++;
  endtask

  task automatic test_overrun();
    logic a;
    bit   e;
    ifc.data_ready_i = 1'b0;
    i2c_start();
    xfer_byte(8'h84, a); e = model_addr(8'h84);
    chk_cnt++; if (a !== e) $display("FAIL ovr_addr_ack: got %b required %b", a, e); else pass_cnt++;
    xfer_byte(8'h01, a); e = model_data(8'h01, 0);
    chk_cnt++; if (a !== e) $display("FAIL ovr_first_ack: got %b required %b", a, e); else pass_cnt++;
    xfer_byte(8'h02, a); e = model_data(8'h02, 0);
    chk_cnt++; if (a !== e) $display("FAIL ovr_second_ack: got %b required %b", a, e); else pass_cnt++;
    chk_cnt++; if (ovr_cnt !== exp_ovr) $display("FAIL ovr_pulses: got %0d required %0d", ovr_cnt, exp_ovr); else pass_cnt++;
    chk_cnt++;
    if ({ifc.data_valid_o, ifc.data_o} !== {m_full, m_byte})
      $display("FAIL ovr_hold: got %b/%h required %b/%h", ifc.data_valid_o, ifc.data_o, m_full, m_byte);
    else pass_cnt++;
    i2c_stop(); m_addressed = 0;
    hp();
    chk_cnt++;
    if (ifc.data_valid_o !== m_full) $display("FAIL ovr_survives_stop: valid %b required %b", ifc.data_valid_o, m_full);
    else pass_cnt++;
    ifc.data_ready_i = 1'b1; model_ready_rise();
    hp();
    chk_cnt++; if (ifc.data_valid_o !== 1'b0) $display("FAIL ovr_drain: valid %b required 0", ifc.data_valid_o); else pass_cnt++;
    chk_cnt++;
    if (!queues_match()) $display("FAIL ovr_delivered: got %0d bytes required %0d", got_q.size(), exp_q.size());
    else pass_cnt++;
  endtask

  task automatic test_restart();
    logic a;
    bit   e;
    i2c_start();
    xfer_byte(8'h84, a); e = model_addr(8'h84);
    chk_cnt++; if (a !== e) $display("FAIL restart_addr_ack: got %b required %b", a, e); else pass_cnt++;
    send_bit(1'b1); send_bit(1'b0); send_bit(1'b1); send_bit(1'b0);
    i2c_start(); m_addressed = 0;
    chk_cnt++; if (ifc.sda_oe_o !== 1'b0) $display("FAIL restart_sda_oe: got %b required 0", ifc.sda_oe_o); else pass_cnt++;
    xfer_byte(8'h84, a); e = model_addr(8'h84);
    chk_cnt++; if (a !== e) $display("FAIL restart_addr2_ack: got %b required %b", a, e); else pass_cnt++;
    xfer_byte(8'h77, a); e = model_data(8'h77, 1);
    chk_cnt++; if (a !== e) $display("FAIL restart_data_ack: got %b required %b", a, e); else pass_cnt++;
    i2c_stop(); m_addressed = 0;
    hp();
    chk_cnt++;
    if (!queues_match()) $display("FAIL restart_delivered: got %0d bytes required %0d", got_q.size(), exp_q.size());
    else pass_cnt++;
  endtask

  task automatic test_reset_mid();
    logic a;
    bit   e;
    ifc.data_ready_i = 1'b0;
    i2c_start();
    xfer_byte(8'h84, a); e = model_addr(8'h84);
    chk_cnt++; if (a !== e) $display("FAIL rstmid_addr_ack: got %b required %b", a, e); else pass_cnt++;
    for (int i = 7; i >= 0; i--) send_bit(1'(8'h99 >> i));
    e = model_data(8'h99, 0);
    tb_sda = 1'b1; hp();
    ifc.scl_i = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk_cnt++;
    if ({ifc.sda_oe_o, ifc.data_valid_o} !== {e, m_full})
      $display("FAIL rstmid_pre: oe/valid %b required %b", {ifc.sda_oe_o, ifc.data_valid_o}, {e, m_full});
    else pass_cnt++;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    m_addressed = 0; m_full = 0;
    chk_cnt++;
    if ({ifc.sda_oe_o, ifc.data_valid_o} !== 2'b00)
      $display("FAIL rstmid_post: oe/valid %b required 00", {ifc.sda_oe_o, ifc.data_valid_o});
    else pass_cnt++;
    hp();
    ifc.scl_i = 1'b0; hp();
    xfer_byte(8'h12, a); e = model_data(8'h12, 0);
    chk_cnt++; if (a !== e) $display("FAIL rstmid_orphan_ack: got %b required %b", a, e); else pass_cnt++;
    chk_cnt++;
    if ({ifc.rx_en_o, ifc.data_valid_o} !== 2'b00)
      $display("FAIL rstmid_idle: en/valid %b required 00", {ifc.rx_en_o, ifc.data_valid_o});
    else pass_cnt++;
    i2c_stop();
    ifc.data_ready_i = 1'b1; model_ready_rise();
    i2c_start();
    xfer_byte(8'h84, a); e = model_addr(8'h84);
    chk_cnt++; if (a !== e) $display("FAIL rstmid_new_addr_ack: got %b required %b", a, e); else pass_cnt++;
    xfer_byte(8'h34, a); e = model_data(8'h34, 1);
    chk_cnt++; if (a !== e) $display("FAIL rstmid_new_data_ack: got %b required %b", a, e); else pass_cnt++;
    i2c_stop(); m_addressed = 0;
    hp();
    chk_cnt++;
    if (!queues_match()) $display("FAIL rstmid_delivered: got %0d bytes required %0d", got_q.size(), exp_q.size());
    else pass_cnt++;
  endtask

  task automatic test_random();
    logic       a;
    bit         e;
    logic [7:0] addr, d;
    int         n;
    ifc.data_ready_i = 1'b1;
    for (int t = 0; t < 6; t++) begin
      addr = ($urandom_range(0, 1) == 1) ? 8'h84 : 8'($urandom);
      n    = $urandom_range(1, 3);
      i2c_start();
      xfer_byte(addr, a); e = model_addr(addr);
      chk_cnt++; if (a !== e) $display("FAIL rand_addr_ack %h: got %b required %b", addr, a, e); else pass_cnt++;
      for (int j = 0; j < n; j++) begin
        d = 8'($urandom);
        xfer_byte(d, a); e = model_data(d, 1);
        chk_cnt++; if (a !== e) $display("FAIL rand_data_ack %h: got %b required %b", d, a, e); else pass_cnt++;
      end
      i2c_stop(); m_addressed = 0;
    end
    hp();
    chk_cnt++;
    if (!queues_match()) $display("FAIL rand_delivered: got %0d bytes required %0d", got_q.size(), exp_q.size());
    else pass_cnt++;
  endtask

  initial begin
    #700000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt + 1);
    $fatal(1);
  end

  initial begin
    rst              = 1'b1;
    tb_sda           = 1'b1;
    ifc.scl_i        = 1'b1;
    ifc.data_ready_i = 1'b0;
    m_addressed = 0; m_full = 0; m_byte = 8'h00;
    test_reset();
    test_write_basic();
    test_addr_mismatch();
    test_read_req();
    test_overrun();
    test_restart();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
